// File: rtl/dwt_cap_pkg.sv
`default_nettype none
// ============================================================================
// Package : dwt_cap_pkg
// Purpose : Shared types and default sizing for the DWT subband frame
//           capture block (capture FSM state encoding, default widths).
// Revision: 1.0  initial release
// ============================================================================
package dwt_cap_pkg;

    localparam int DEF_DATA_W = 40;   // signed subband sample width
    localparam int DEF_DEPTH  = 196;  // one 14x14 subband frame
    localparam int DEF_CH     = 4;    // LL, LH, HL, HH

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwt_cap_ram.sv
`default_nettype none
// ============================================================================
// Module  : dwt_cap_ram
// Purpose : DEPTH x DATA_W single-port-write / single-port-read memory with
//           synchronous write and registered synchronous read. A read and a
//           write to the same address in one cycle return the old contents.
// Ports   : clk, rstn           clock, async active-low reset (read reg only)
//           wr_en_i/addr/data   write port
//           rd_en_i/addr        read request; rd_data_o valid next cycle,
//                               held while rd_en_i is low
// Revision: 1.0  initial release
// ============================================================================
module dwt_cap_ram #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 196,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Array itself is never reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/dwt_frame_capture.sv
`default_nettype none
// ============================================================================
// Module  : dwt_frame_capture
// Purpose : Captures CH independent DWT subband sample streams into per-
//           channel DEPTH-entry memories, in one-shot or continuous-ring
//           mode, with a registered readout port usable in every state.
// Ports   : clk, rstn             clock, async active-low reset
//           arm, mode, stop       control pulses; mode sampled on arm
//           in_valid, in_data     per-channel sample strobes / packed data
//           rd_en, rd_ch, rd_addr readout request
//           rd_data, rd_valid     readout result, one cycle later
//           busy, done            CAPTURE / DONE state indicators
//           overflow, wrapped     sticky status flags
//           checksum              per-channel running XOR of accepted samples
//                                 (only when DWT_CAP_CHECKSUM_EN is defined)
// Options : DWT_CAP_CHECKSUM_EN   adds the checksum output and its logic
// Revision: 1.0  initial release
// ============================================================================
module dwt_frame_capture
    import dwt_cap_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int CH     = DEF_CH,
    localparam int AW     = idx_w(DEPTH),
    localparam int CHW    = idx_w(CH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic                 mode,
    input  logic                 stop,
    input  logic [CH-1:0]        in_valid,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 rd_en,
    input  logic [CHW-1:0]       rd_ch,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [CH-1:0]        wrapped
`ifdef DWT_CAP_CHECKSUM_EN
    ,
    output logic [CH*DATA_W-1:0] checksum
`endif
);

    // Counters must be able to hold DEPTH itself (the "full" value).
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    cap_state_e        state_q, state_d;
    logic              mode_q, mode_d;
    logic              overflow_q, overflow_d;
    logic [CH-1:0]     wrapped_q, wrapped_d;
    logic [CW-1:0]     cnt_q [CH];
    logic [CW-1:0]     cnt_d [CH];
    logic [CH-1:0]     wr_en;
    logic              all_full;

    logic              rd_valid_q;
    logic [CHW-1:0]    rd_ch_q;
    logic              rd_oob_q;
    logic [DATA_W-1:0] ram_q [CH];

    // ------------------------------------------------------------------
    // Next-state / write-enable logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        overflow_d = overflow_q;
        wrapped_d  = wrapped_q;
        wr_en      = '0;
        all_full   = 1'b1;
        for (int c = 0; c < CH; c++) begin
            cnt_d[c] = cnt_q[c];
        end

        if (arm) begin
            // arm overrides stop and suppresses any write in the same cycle
            state_d    = ST_CAPTURE;
            mode_d     = mode;
            overflow_d = 1'b0;
            wrapped_d  = '0;
            for (int c = 0; c < CH; c++) begin
                cnt_d[c] = '0;
            end
        end else if (state_q == ST_CAPTURE) begin
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c]) begin
                    if (cnt_q[c] < DEPTH_C) begin
                        wr_en[c] = 1'b1;
                        if (mode_q && (cnt_q[c] == LAST_C)) begin
                            cnt_d[c]     = '0;
                            wrapped_d[c] = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + CW'(1);
                        end
                    end else begin
                        // only reachable in one-shot: ring mode never hits DEPTH
                        overflow_d = 1'b1;
                    end
                end
            end
            // look at post-write counts so the last write completes the frame
            for (int c = 0; c < CH; c++) begin
                if (cnt_d[c] != DEPTH_C) begin
                    all_full = 1'b0;
                end
            end
            if (stop) begin
                state_d = ST_IDLE;
            end else if (!mode_q && all_full) begin
                state_d = ST_DONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and readout registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
            wrapped_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                cnt_q[c] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            overflow_q <= overflow_d;
            wrapped_q  <= wrapped_d;
            for (int c = 0; c < CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_ch_q  <= rd_ch;
                rd_oob_q <= ({1'b0, rd_ch} >= (CHW + 1)'(CH));
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel memories; all lanes read together, selection is by the
    // channel registered with the request so rd_data holds with rd_en low.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CH; c++) begin : g_lane
        dwt_cap_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_ram (
            .clk       (clk),
            .rstn      (rstn),
            .wr_en_i   (wr_en[c]),
            .wr_addr_i (cnt_q[c][AW-1:0]),
            .wr_data_i (in_data[c*DATA_W +: DATA_W]),
            .rd_en_i   (rd_en),
            .rd_addr_i (rd_addr),
            .rd_data_o (ram_q[c])
        );
    end

    always_comb begin
        rd_data = '0;
        if (!rd_oob_q) begin
            for (int c = 0; c < CH; c++) begin
                if (rd_ch_q == CHW'(c)) begin
                    rd_data = ram_q[c];
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_DONE);
    assign overflow = overflow_q;
    assign wrapped  = wrapped_q;

`ifdef DWT_CAP_CHECKSUM_EN
    logic [CH*DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            checksum_q <= '0;
        end else if (arm) begin
            checksum_q <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (wr_en[c]) begin
                    checksum_q[c*DATA_W +: DATA_W] <=
                        checksum_q[c*DATA_W +: DATA_W] ^ in_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dwt_frame_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_dwt_frame_capture
// Purpose : Self-checking bench for dwt_frame_capture (default sizing,
//           CH=4, DEPTH=196, DATA_W=40). Readout expectations are pushed to
//           a scoreboard queue when a read is issued and popped when the
//           DUT returns rd_valid.
// Options : DWT_CAP_CHECKSUM_EN   also exercises the checksum output
// Revision: 1.0  initial release
// ============================================================================
module tb_dwt_frame_capture;

    localparam int DATA_W = 40;
    localparam int DEPTH  = 196;
    localparam int CH     = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 arm;
    logic                 mode;
    logic                 stop;
    logic [CH-1:0]        in_valid;
    logic [CH*DATA_W-1:0] in_data;
    logic                 rd_en;
    logic [1:0]           rd_ch;
    logic [7:0]           rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [CH-1:0]        wrapped;
`ifdef DWT_CAP_CHECKSUM_EN
    logic [CH*DATA_W-1:0] checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] sb [$];

    always #5 clk = ~clk;

    dwt_frame_capture u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .arm      (arm),
        .mode     (mode),
        .stop     (stop),
        .in_valid (in_valid),
        .in_data  (in_data),
        .rd_en    (rd_en),
        .rd_ch    (rd_ch),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .wrapped  (wrapped)
`ifdef DWT_CAP_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // inputs change 1 time unit after the rising edge, outputs sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int c, input logic [DATA_W-1:0] v);
        in_data[c*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_arm(input logic m);
        arm  = 1'b1;
        mode = m;
        tick();
        arm  = 1'b0;
    endtask

    task automatic issue_read(input logic [1:0] ch, input logic [7:0] addr,
                              input logic [DATA_W-1:0] exp);
        rd_en   = 1'b1;
        rd_ch   = ch;
        rd_addr = addr;
        sb.push_back(exp);
        tick();
        rd_en   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({busy, done, overflow, wrapped, rd_valid} !== 8'h00 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b done=%0b ovf=%0b wrapped=%b rd_valid=%0b rd_data=%0h, required all 0",
                     busy, done, overflow, wrapped, rd_valid, rd_data);
        end
        rstn = 1'b1;
        tick();
        in_valid = 4'hF;
        tick();
        in_valid = '0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_oneshot();
        logic [1:0]        rc [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        logic [7:0]        ra [4] = '{8'd195, 8'd0, 8'd100, 8'd17};
        logic [DATA_W-1:0] re [4] = '{40'd2195, 40'd0, 40'd3100, 40'd1017};
        logic [DATA_W-1:0] e;
        do_arm(1'b0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_busy: busy=%0b, required 1", busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < CH; c++) set_lane(c, DATA_W'(c * 1000 + i));
            in_valid = 4'hF;
            tick();
            if (i == DEPTH - 2) begin
                n_tests++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL oneshot_early_done: done=%0b busy=%0b after 195 writes, required 0 1", done, busy);
                end
            end
        end
        in_valid = '0;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_done: done=%0b busy=%0b after 196 writes, required 1 0", done, busy);
        end
        // valids in DONE are ignored and do not flag overflow
        in_valid = 4'hF;
        for (int c = 0; c < CH; c++) set_lane(c, 40'hDEAD);
        repeat (2) tick();
        in_valid = '0;
        n_tests++;
        if (overflow !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ignore: overflow=%0b done=%0b, required 0 1", overflow, done);
        end
        for (int k = 0; k < 4; k++) begin
            issue_read(rc[k], ra[k], re[k]);
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++;
                $display("FAIL oneshot_rd(%0d,%0d): got %0d valid=%0b, required %0d",
                         rc[k], ra[k], rd_data, rd_valid, e);
            end
        end
        tick();
        n_tests++;
        if (rd_valid !== 1'b0 || rd_data !== 40'd1017) begin
            n_fail++;
            $display("FAIL rd_hold: rd_data=%0d rd_valid=%0b, required 1017 0", rd_data, rd_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow();
        logic [1:0]        rc [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0]        ra [5] = '{8'd0, 8'd1, 8'd2, 8'd195, 8'd50};
        logic [DATA_W-1:0] re [5] = '{40'd1000, 40'd1001, 40'd1002, 40'd1195, 40'd50};
        logic [DATA_W-1:0] e;
        do_arm(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            set_lane(0, DATA_W'(i));
            set_lane(1, DATA_W'(1000 + i));
            in_valid = {2'b00, 1'b1, (i < 50)};
            tick();
        end
        in_valid = '0;
        n_tests++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_before: overflow=%0b busy=%0b with ch1 just full, required 0 1", overflow, busy);
        end
        set_lane(1, 40'd7777);
        in_valid = 4'b0010;
        repeat (3) tick();
        in_valid = '0;
        n_tests++;
        if (overflow !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%0b done=%0b busy=%0b, required 1 0 1", overflow, done, busy);
        end
        for (int k = 0; k < 5; k++) begin
            issue_read(rc[k], ra[k], re[k]);
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++;
                $display("FAIL ovf_rd(%0d,%0d): got %0d valid=%0b, required %0d",
                         rc[k], ra[k], rd_data, rd_valid, e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_continuous();
        logic [1:0]        rc [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        logic [7:0]        ra [4] = '{8'd0, 8'd1, 8'd2, 8'd0};
        logic [DATA_W-1:0] re [4] = '{40'd196, 40'd197, 40'd2, 40'd1000};
        logic [DATA_W-1:0] e;
        do_arm(1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_clears_ovf: overflow=%0b, required 0", overflow);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_lane(0, DATA_W'(i));
            in_valid = 4'b0001;
            tick();
            if (i == 99) begin
                n_tests++;
                if (wrapped !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL ring_nowrap: wrapped=%b after 100 writes, required 0000", wrapped);
                end
            end
        end
        in_valid = '0;
        n_tests++;
        if (wrapped !== 4'b0001 || done !== 1'b0 || busy !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ring_wrap: wrapped=%b done=%0b busy=%0b ovf=%0b, required 0001 0 1 0",
                     wrapped, done, busy, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            issue_read(rc[k], ra[k], re[k]);
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++;
                $display("FAIL ring_rd(%0d,%0d): got %0d valid=%0b, required %0d",
                         rc[k], ra[k], rd_data, rd_valid, e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_arm_stop();
        logic [1:0]        rc [3] = '{2'd0, 2'd0, 2'd0};
        logic [7:0]        ra [3] = '{8'd0, 8'd1, 8'd5};
        logic [DATA_W-1:0] re [3] = '{40'hABC, 40'd257, 40'd5};
        logic [DATA_W-1:0] e;
        do_arm(1'b0);
        n_tests++;
        if (wrapped !== 4'b0000) begin
            n_fail++;
            $display("FAIL arm_clears_wrap: wrapped=%b, required 0000", wrapped);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            set_lane(0, DATA_W'(256 + i));
            set_lane(2, DATA_W'(2000 + i));
            in_valid = {1'b0, 1'b1, 1'b0, (i < 5)};
            tick();
        end
        // arm + stop + a write in the same cycle: arm wins, write dropped
        arm      = 1'b1;
        stop     = 1'b1;
        mode     = 1'b0;
        in_valid = 4'b0001;
        set_lane(0, 40'h555);
        tick();
        arm      = 1'b0;
        stop     = 1'b0;
        in_valid = '0;
        n_tests++;
        if (busy !== 1'b1 || overflow !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_stop: busy=%0b ovf=%0b done=%0b, required 1 0 0", busy, overflow, done);
        end
        set_lane(0, 40'hABC);
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        for (int k = 0; k < 3; k++) begin
            issue_read(rc[k], ra[k], re[k]);
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++;
                $display("FAIL armstop_rd(%0d,%0d): got %0h valid=%0b, required %0h",
                         rc[k], ra[k], rd_data, rd_valid, e);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%0b done=%0b, required 0 0", busy, done);
        end
        issue_read(2'd0, 8'd0, 40'hABC);
        e = sb.pop_front();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_fail++;
            $display("FAIL stop_retain: got %0h valid=%0b, required %0h", rd_data, rd_valid, e);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [1:0]        rc [2] = '{2'd3, 2'd3};
        logic [7:0]        ra [2] = '{8'd0, 8'd1};
        logic [DATA_W-1:0] re [2] = '{40'h3333, 40'h32001};
        logic [DATA_W-1:0] e;
        do_arm(1'b0);
        for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < CH; c++) set_lane(c, DATA_W'(c * 32'h10000 + 32'h2000 + i));
            in_valid = 4'hF;
            tick();
        end
        in_valid = '0;
        rstn     = 1'b0;
        #2;
        n_tests++;
        if ({busy, done, overflow, wrapped, rd_valid} !== 8'h00 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: busy=%0b done=%0b ovf=%0b wrapped=%b rd_valid=%0b rd_data=%0h, required all 0",
                     busy, done, overflow, wrapped, rd_valid, rd_data);
        end
        tick();
        rstn = 1'b1;
        tick();
        set_lane(3, 40'h9999);
        in_valid = 4'b1000;
        tick();
        in_valid = '0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: busy=%0b, required 0", busy);
        end
        do_arm(1'b0);
        set_lane(3, 40'h3333);
        in_valid = 4'b1000;
        tick();
        in_valid = '0;
        for (int k = 0; k < 2; k++) begin
            issue_read(rc[k], ra[k], re[k]);
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++;
                $display("FAIL midrst_rd(%0d,%0d): got %0h valid=%0b, required %0h",
                         rc[k], ra[k], rd_data, rd_valid, e);
            end
        end
    endtask

`ifdef DWT_CAP_CHECKSUM_EN
    // ------------------------------------------------------------------
    task automatic test_checksum();
        logic [DATA_W-1:0] vals [4] = '{40'd5, 40'd3, 40'd6, 40'd9};
        logic [DATA_W-1:0] exps [4] = '{40'd5, 40'd6, 40'd0, 40'd9};
        do_arm(1'b0);
        for (int k = 0; k < 4; k++) begin
            set_lane(0, vals[k]);
            in_valid = 4'b0001;
            tick();
            n_tests++;
            if (checksum[DATA_W-1:0] !== exps[k]) begin
                n_fail++;
                $display("FAIL checksum_lane0[%0d]: got %0d, required %0d", k, checksum[DATA_W-1:0], exps[k]);
            end
        end
        in_valid = '0;
        do_arm(1'b0);
        n_tests++;
        if (checksum !== '0) begin
            n_fail++;
            $display("FAIL checksum_arm: got %0h, required 0", checksum);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        arm      = 1'b0;
        mode     = 1'b0;
        stop     = 1'b0;
        in_valid = '0;
        in_data  = '0;
        rd_en    = 1'b0;
        rd_ch    = '0;
        rd_addr  = '0;
        test_reset();
        test_oneshot();
        test_overflow();
        test_continuous();
        test_arm_stop();
        test_reset_mid();
`ifdef DWT_CAP_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dwt_frame_capture.md
DWT_FRAME_CAPTURE -- requirements
Module: dwt_frame_capture

Interface
REQ-001 Parameter DATA_W, default 40, width of one signed subband sample.
REQ-002 Parameter DEPTH, default 196 (one 14x14 subband frame), samples captured per channel.
REQ-003 Parameter CH, default 4, number of subband channels (LL, LH, HL, HH).
REQ-004 Localparam AW = clog2(DEPTH), address width.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 arm  input  1  one-cycle pulse; clears counters and starts capture.
REQ-008 mode  input  1  0 = one-shot, 1 = continuous ring; sampled on arm.
REQ-009 stop  input  1  one-cycle pulse; ends capture and returns to IDLE.
REQ-010 in_valid  input  CH  per-channel sample strobe.
REQ-011 in_data  input  CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
REQ-012 rd_en  input  1  readout request.
REQ-013 rd_ch  input  clog2(CH)  readout channel.
REQ-014 rd_addr  input  AW  readout address.
REQ-015 rd_data  output  DATA_W  sample at {rd_ch, rd_addr}.
REQ-016 rd_valid  output  1  high one cycle after an accepted rd_en.
REQ-017 busy  output  1  high in CAPTURE.
REQ-018 done  output  1  high in DONE.
REQ-019 overflow  output  1  sticky; a sample was dropped.
REQ-020 wrapped  output  CH  sticky per channel; ring pointer has wrapped.

Function
REQ-021 FSM states: IDLE, CAPTURE, DONE; transitions only as listed in REQ-022 to REQ-025.
REQ-022 arm in any state -> CAPTURE next cycle; clears all counters, overflow and wrapped; latches mode.
REQ-023 In CAPTURE, in_valid[c] with cnt[c] < DEPTH writes in_data channel c to mem[c][cnt[c]] and increments cnt[c]; channels are independent and may write in the same cycle.
REQ-024 One-shot: when every cnt[c] == DEPTH (including on the same edge as the final write) -> DONE; in DONE, in_valid is ignored and does not set overflow.
REQ-025 stop in CAPTURE -> IDLE; memory contents are retained.
REQ-026 One-shot: in_valid[c] in CAPTURE with cnt[c] == DEPTH sets overflow; no write is performed.
REQ-027 Continuous: cnt[c] wraps from DEPTH-1 to 0, the write proceeds, and wrapped[c] is set; the FSM never enters DONE.
REQ-028 arm and stop in the same cycle: arm wins.
REQ-029 arm coincident with a write: the write is dropped and counters restart at 0.
REQ-030 Readout is allowed in every state; rd_data is registered with 1-cycle latency; a read and a write to the same address in the same cycle return the old data.
REQ-031 rd_ch >= CH returns 0 with rd_valid still asserted.
REQ-032 rd_data holds its value when rd_en is low.

Reset
REQ-033 Reset puts the FSM in IDLE; busy, done, overflow, wrapped, rd_valid, rd_data and all cnt are 0.
REQ-034 Memory contents are not reset.
REQ-035 Reset asserted mid-capture aborts immediately; after release the block stays in IDLE until arm.

Configuration
REQ-036 When DWT_CAP_CHECKSUM_EN is defined: add output checksum, width CH*DATA_W; each lane holds the running XOR of the accepted samples of that channel, cleared by reset and by arm.
REQ-037 When DWT_CAP_CHECKSUM_EN is undefined: no checksum port and no checksum logic.

Structure
REQ-038 Package dwt_cap_pkg holds the FSM state typedef and the default DATA_W, DEPTH and CH constants.
REQ-039 Sub-module dwt_cap_ram: one sync-write/sync-read DEPTH x DATA_W memory, instantiated CH times.

Verification
REQ-040 One-shot, CH=4, DEPTH=196: drive ramp data v=c*1000+i on all channels every cycle -> done after the 196th write; rd(2,195) = 2195.
REQ-041 One-shot, continue 3 valids on ch1 after full while ch0 still filling -> overflow=1; rd(1,0..2) unchanged.
REQ-042 Continuous, DEPTH=8: write 10 samples 0..9 on ch0 -> wrapped[0]=1; rd(0,0)=8, rd(0,1)=9, rd(0,2)=2; done stays 0.
REQ-043 arm and stop in the same cycle during CAPTURE -> busy=1, cnt cleared, overflow=0.
REQ-044 Reset pulse at sample 100 -> all outputs 0, IDLE; next arm captures from address 0.
REQ-045 With DWT_CAP_CHECKSUM_EN: samples 5, 3, 6 on ch0 -> checksum lane0 = 0; arm -> 0.
